// File: rtl/upg_loader_ctrl.sv
// rtl/upg_loader_ctrl.sv - UART frame loader driving the shared imem/dmem programming port
// Optional trailing XOR checksum byte is enabled by defining UPG_CHECKSUM_EN.
module upg_loader_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              prog_mode_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W:0]   upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TGT    = 3'd1;
    localparam logic [2:0] S_CNT_LO = 3'd2;
    localparam logic [2:0] S_CNT_HI = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
`ifdef UPG_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd5;
`endif
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam int          TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [2:0]        state;
    logic              prog_q;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit;
    logic              tgt;
    logic [7:0]        cnt_lo;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       shift;
    logic              last_word;
    logic [2:0]        end_state;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]        csum;

    assign end_state = S_CSUM;
`else
    assign end_state = S_DONE;
`endif

    // Idle-cycle count reaches the limit on the TIMEOUT_CYC-th consecutive cycle without a byte
    assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !rx_valid_i;
    assign last_word = (17'(word_idx) + 17'd1) == {1'b0, n_words};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prog_q     <= 1'b0;
            to_cnt     <= '0;
            tgt        <= 1'b0;
            cnt_lo     <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            upg_rst_o  <= 1'b1;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
            err_o      <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            prog_q    <= prog_mode_i;
            upg_wen_o <= 1'b0;
            if (state != S_IDLE && !prog_mode_i) begin
                state      <= S_IDLE;
                upg_rst_o  <= 1'b1;
                upg_done_o <= 1'b0;
                if (state != S_DONE) err_o <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (prog_mode_i && !prog_q) begin
                            state     <= S_TGT;
                            upg_rst_o <= 1'b0;
                            err_o     <= 1'b0;
                            to_cnt    <= '0;
                            word_idx  <= '0;
                            byte_idx  <= '0;
`ifdef UPG_CHECKSUM_EN
                            csum      <= '0;
`endif
                        end
                    end
                    S_DONE: upg_done_o <= 1'b1;
                    S_ERR: ;
                    default: begin
                        to_cnt <= rx_valid_i ? '0 : to_cnt + TO_W'(1);
                        if (to_hit) begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end else if (rx_valid_i) begin
                            case (state)
                                S_TGT: begin
                                    if (rx_data_i > 8'd1) begin
                                        state <= S_ERR;
                                        err_o <= 1'b1;
                                    end else begin
                                        tgt   <= rx_data_i[0];
                                        state <= S_CNT_LO;
                                    end
                                end
                                S_CNT_LO: begin
                                    cnt_lo <= rx_data_i;
                                    state  <= S_CNT_HI;
                                end
                                S_CNT_HI: begin
                                    n_words <= {rx_data_i, cnt_lo};
                                    if ({1'b0, rx_data_i, cnt_lo} > MAX_WORDS) begin
                                        state <= S_ERR;
                                        err_o <= 1'b1;
                                    end else if ({rx_data_i, cnt_lo} == 16'd0) begin
                                        state <= end_state;
                                    end else begin
                                        state <= S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    byte_idx <= byte_idx + 2'd1;
                                    shift    <= {rx_data_i, shift[23:8]};
`ifdef UPG_CHECKSUM_EN
                                    csum     <= csum ^ rx_data_i;
`endif
                                    // Fourth byte completes the word; shift holds bytes 2..0
                                    if (byte_idx == 2'd3) begin
                                        upg_wen_o <= 1'b1;
                                        upg_adr_o <= {tgt, word_idx};
                                        upg_dat_o <= {rx_data_i, shift};
                                        word_idx  <= word_idx + ADDR_W'(1);
                                        if (last_word) state <= end_state;
                                    end
                                end
`ifdef UPG_CHECKSUM_EN
                                S_CSUM: begin
                                    if (rx_data_i == csum) begin
                                        state <= S_DONE;
                                    end else begin
                                        state <= S_ERR;
                                        err_o <= 1'b1;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule
